// File: rtl/fb_sched_pkg.sv
// fb_sched_pkg: shared state type, default geometry and owner mapping for fb_write_scheduler.
package fb_sched_pkg;
    typedef enum logic {CLEAR, RUN} fb_state_t;
    localparam int COORD_W_DEF = 11;
    localparam int X_MAX_DEF = 640;
    localparam int Y_MAX_DEF = 480;
    function automatic logic [1:0] map_sel(input logic [1:0] sel, input int num_req);
        return (int'(sel) >= num_req) ? 2'(num_req - 1) : sel;
    endfunction
endpackage

// File: rtl/fb_write_scheduler_if.sv
// fb_write_scheduler_if: requester and framebuffer signals of the write scheduler.
interface fb_write_scheduler_if #(parameter int NUM_REQ = 3, parameter int COORD_W = 11);
    logic [1:0] sel;
    logic [NUM_REQ-1:0][COORD_W-1:0] req_x;
    logic [NUM_REQ-1:0][COORD_W-1:0] req_y;
    logic [NUM_REQ-1:0] req_color;
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0] anim_start;
    logic [COORD_W-1:0] fb_x;
    logic [COORD_W-1:0] fb_y;
    logic fb_color;
    logic fb_write;
    logic clearing;
    modport master (output sel, req_x, req_y, req_color, req_valid,
                    input req_ready, anim_start, fb_x, fb_y, fb_color, fb_write, clearing);
    modport slave (input sel, req_x, req_y, req_color, req_valid,
                   output req_ready, anim_start, fb_x, fb_y, fb_color, fb_write, clearing);
endinterface

// File: rtl/fb_clear_sweep.sv
// fb_clear_sweep: raster counter over the screen used to clear it to black.
module fb_clear_sweep #(
    parameter int COORD_W = 11,
    parameter int X_MAX = 640,
    parameter int Y_MAX = 480
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    input  logic enable,
    output logic [COORD_W-1:0] cx,
    output logic [COORD_W-1:0] cy,
    output logic last
);
    logic x_end, y_end;
    assign x_end = cx == COORD_W'(X_MAX - 1);
    assign y_end = cy == COORD_W'(Y_MAX - 1);
    assign last = x_end && y_end;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cx <= '0;
            cy <= '0;
        end else if (restart) begin
            cx <= '0;
            cy <= '0;
        end else if (enable) begin
            cx <= x_end ? '0 : cx + 1'b1;
            cy <= x_end ? (y_end ? '0 : cy + 1'b1) : cy;
        end
    end
endmodule

// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler: shares the framebuffer write port between animation engines, clearing the
// screen on every owner change. Define FB_BOUNDS_CHECK_EN to suppress off-screen owner writes.
module fb_write_scheduler
    import fb_sched_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int COORD_W = COORD_W_DEF,
    parameter int X_MAX = X_MAX_DEF,
    parameter int Y_MAX = Y_MAX_DEF
) (
    input logic clk,
    input logic reset_n,
    fb_write_scheduler_if.slave bus
);
    fb_state_t state;
    logic [1:0] owner, sel_m;
    logic [COORD_W-1:0] cx, cy;
    logic last, change, in_bounds;
    logic [NUM_REQ-1:0] owner_oh;
    assign sel_m = map_sel(bus.sel, NUM_REQ);
    assign owner_oh = NUM_REQ'(1) << owner;
    assign change = state == RUN && sel_m != owner;
    assign bus.req_ready = state == RUN ? owner_oh : '0;
`ifdef FB_BOUNDS_CHECK_EN
    assign in_bounds = bus.req_x[owner] < COORD_W'(X_MAX) && bus.req_y[owner] < COORD_W'(Y_MAX);
`else
    assign in_bounds = 1'b1;
`endif
    fb_clear_sweep #(.COORD_W(COORD_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX)) u_sweep (
        .clk(clk),
        .reset_n(reset_n),
        .restart(state == RUN),
        .enable(state == CLEAR),
        .cx(cx),
        .cy(cy),
        .last(last)
    );
    // Owner is frozen on the final sweep cycle so a late sel change is seen as a fresh change in RUN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= CLEAR;
            owner <= '0;
            bus.fb_x <= '0;
            bus.fb_y <= '0;
            bus.fb_color <= 1'b0;
            bus.fb_write <= 1'b0;
            bus.anim_start <= '0;
            bus.clearing <= 1'b1;
        end else if (state == CLEAR) begin
            bus.fb_x <= cx;
            bus.fb_y <= cy;
            bus.fb_color <= 1'b0;
            bus.fb_write <= 1'b1;
            bus.anim_start <= last ? owner_oh : '0;
            bus.clearing <= 1'b1;
            owner <= last ? owner : sel_m;
            state <= last ? RUN : CLEAR;
        end else begin
            bus.fb_x <= bus.req_x[owner];
            bus.fb_y <= bus.req_y[owner];
            bus.fb_color <= bus.req_color[owner];
            bus.fb_write <= bus.req_valid[owner] && in_bounds && !change;
            bus.anim_start <= '0;
            bus.clearing <= change;
            owner <= sel_m;
            state <= change ? CLEAR : RUN;
        end
    end
endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb_fb_write_scheduler: scoreboard bench for fb_write_scheduler on a 4x3 screen.
module tb_fb_write_scheduler;
    typedef struct {
        logic [10:0] x;
        logic [10:0] y;
        logic c;
    } px_t;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int n_chk = 0;
    int n_pass = 0;
    px_t exp_q[$];
    logic [2:0] anim_q[$];
    fb_write_scheduler_if #(.NUM_REQ(3), .COORD_W(11)) bus ();
    fb_write_scheduler #(.NUM_REQ(3), .COORD_W(11), .X_MAX(4), .Y_MAX(3)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask
    task automatic push_px(input logic [10:0] x, input logic [10:0] y, input logic c);
        px_t p;
        p.x = x;
        p.y = y;
        p.c = c;
        exp_q.push_back(p);
    endtask
    task automatic push_sweep(input logic [2:0] anim);
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++) push_px(11'(x), 11'(y), 1'b0);
        anim_q.push_back(anim);
    endtask
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.fb_write) begin
                if (exp_q.size() == 0) chk("spurious_wr", 32'(bus.fb_write), 0);
                else begin
                    px_t p;
                    p = exp_q.pop_front();
                    chk("wr_x", 32'(bus.fb_x), 32'(p.x));
                    chk("wr_y", 32'(bus.fb_y), 32'(p.y));
                    chk("wr_color", 32'(bus.fb_color), 32'(p.c));
                end
            end
            if (bus.anim_start != 0) begin
                if (anim_q.size() == 0) chk("spurious_anim", 32'(bus.anim_start), 0);
                else chk("anim", 32'(bus.anim_start), 32'(anim_q.pop_front()));
            end
        end
    end
    initial begin
        bus.sel = 2'd0;
        bus.req_x = '0;
        bus.req_y = '0;
        bus.req_color = '0;
        bus.req_valid = '0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_write", 32'(bus.fb_write), 0);
        chk("rst_clearing", 32'(bus.clearing), 1);
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_anim", 32'(bus.anim_start), 0);
        chk("rst_xy", 32'({bus.fb_x, bus.fb_y}), 0);
        tick(2);
        push_sweep(3'b001);
        reset_n = 1'b1;
        tick(12);
        chk("t1_clearing_last", 32'(bus.clearing), 1);
        tick();
        chk("t1_clearing_fall", 32'(bus.clearing), 0);
        chk("t1_ready", 32'(bus.req_ready), 3'b001);
        bus.sel = 2'd1;
        push_sweep(3'b010);
        tick();
        chk("t2_gap_write", 32'(bus.fb_write), 0);
        chk("t2_gap_clearing", 32'(bus.clearing), 1);
        chk("t2_gap_ready", 32'(bus.req_ready), 0);
        tick(13);
        chk("t2_ready", 32'(bus.req_ready), 3'b010);
        bus.req_x[0] = 11'd3;
        bus.req_y[0] = 11'd2;
        bus.req_x[1] = 11'd2;
        bus.req_y[1] = 11'd1;
        bus.req_x[2] = 11'd0;
        bus.req_y[2] = 11'd2;
        bus.req_color = 3'b010;
        bus.req_valid = 3'b111;
        push_px(11'd2, 11'd1, 1'b1);
        tick();
        chk("t2_write", 32'(bus.fb_write), 1);
        bus.req_valid = 3'b101;
        bus.req_color = 3'b101;
        tick();
        chk("t2_nonowner", 32'(bus.fb_write), 0);
        bus.req_valid = 3'b000;
        bus.sel = 2'd2;
        push_sweep(3'b100);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("t3_ready_sweep", 32'(bus.req_ready), 0);
        end
        tick();
        chk("t3_clearing_last", 32'(bus.clearing), 1);
        tick();
        chk("t3_ready", 32'(bus.req_ready), 3'b100);
        bus.sel = 2'd1;
        push_sweep(3'b001);
        tick();
        chk("t4_gap_write", 32'(bus.fb_write), 0);
        tick(5);
        bus.sel = 2'd0;
        tick(7);
        chk("t4_clearing_last", 32'(bus.clearing), 1);
        tick();
        chk("t4_ready", 32'(bus.req_ready), 3'b001);
        chk("t4_clearing", 32'(bus.clearing), 0);
        bus.sel = 2'd3;
        push_sweep(3'b100);
        tick(14);
        chk("t5_ready", 32'(bus.req_ready), 3'b100);
        bus.req_x[2] = 11'd1;
        bus.req_y[2] = 11'd1;
        bus.req_color = 3'b100;
        bus.req_valid = 3'b100;
        push_px(11'd1, 11'd1, 1'b1);
        tick();
        chk("t5_write", 32'(bus.fb_write), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_async_write", 32'(bus.fb_write), 0);
        chk("t5_async_clearing", 32'(bus.clearing), 1);
        chk("t5_async_ready", 32'(bus.req_ready), 0);
        bus.req_valid = 3'b000;
        tick(2);
        push_sweep(3'b100);
        reset_n = 1'b1;
        tick(12);
        chk("t5_clearing_last", 32'(bus.clearing), 1);
        tick();
        chk("t5_ready_after", 32'(bus.req_ready), 3'b100);
        bus.req_x[2] = 11'd4;
        bus.req_y[2] = 11'd0;
        bus.req_color = 3'b100;
        bus.req_valid = 3'b100;
`ifndef FB_BOUNDS_CHECK_EN
        push_px(11'd4, 11'd0, 1'b1);
`endif
        chk("t6_ready", 32'(bus.req_ready), 3'b100);
        tick();
`ifdef FB_BOUNDS_CHECK_EN
        chk("t6_write", 32'(bus.fb_write), 0);
`else
        chk("t6_write", 32'(bus.fb_write), 1);
`endif
        chk("t6_x", 32'(bus.fb_x), 4);
        bus.req_valid = 3'b000;
        tick(2);
        chk("pending_px", exp_q.size(), 0);
        chk("pending_anim", anim_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
